// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the fft bit-reverse reorder stage.
// master = upstream/downstream driver side, slave = reorder block.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 34,
  parameter int LOG2N  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic [LOG2N-1:0]  out_index;
  logic              overflow;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out,
    input  out_index, overflow
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out,
    output out_index, overflow
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reverse to natural order frame reorder.
// Optional macro REORDER_SCALE_EN: 1/N scaling on read path.
module fft_bitrev_reorder #(
  parameter int DATA_W = 34,
  parameter int LOG2N  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_bitrev_reorder_if.slave bus
);
  localparam int N = 1 << LOG2N;
  localparam int H = DATA_W / 2;

  logic [DATA_W-1:0] mem [2][N];
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  rd_cnt;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        bank_full;
  logic [1:0]        full_nxt;
  logic              ovf;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_last;
  logic              rd_last;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] scaled;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] k
  );
    for (int i = 0; i < LOG2N; i++)
      bitrev[i] = k[LOG2N-1-i];
  endfunction

  assign bus.in_ready  = ~bank_full[wr_bank];
  assign bus.out_valid = bank_full[rd_bank];
  assign bus.out_index = rd_cnt;
  assign bus.overflow  = ovf;

  assign wr_fire = bus.in_valid & bus.in_ready;
  assign rd_fire = bus.out_valid & bus.out_ready;
  assign wr_last = &wr_cnt;
  assign rd_last = &rd_cnt;

  assign rd_word = mem[rd_bank][rd_cnt];

`ifdef REORDER_SCALE_EN
  logic signed [H-1:0] re_s;
  logic signed [H-1:0] im_s;
  assign re_s = $signed(rd_word[DATA_W-1:H]) >>> LOG2N;
  assign im_s = $signed(rd_word[H-1:0]) >>> LOG2N;
  assign scaled = {re_s, im_s};
`else
  assign scaled = rd_word;
`endif

  assign bus.data_out = bus.out_valid ? scaled : '0;

  // Sample storage, scattered to bit-reversed slots.
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_bank][bitrev(wr_cnt)] <= bus.data_in;
  end

  // Fill/drain of distinct banks never collide.
  always_comb begin
    full_nxt = bank_full;
    if (wr_fire && wr_last)
      full_nxt[wr_bank] = 1'b1;
    if (rd_fire && rd_last)
      full_nxt[rd_bank] = 1'b0;
  end

  // Write-side pointer and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last)
        wr_bank <= ~wr_bank;
    end
  end

  // Read-side pointer and bank select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_last)
        rd_bank <= ~rd_bank;
    end
  end

  // Bank occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bank_full <= '0;
    else
      bank_full <= full_nxt;
  end

  // Sticky drop indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (bus.in_valid && !bus.in_ready)
      ovf <= 1'b1;
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder.
// Frame-level reference model plus directed tables.
module tb_fft_bitrev_reorder;
  localparam int DW = 34;
  localparam int LG = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_W(DW), .LOG2N(LG)) bus ();

  fft_bitrev_reorder #(.DATA_W(DW), .LOG2N(LG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]    idx;
    logic [DW-1:0] data;
  } smp_t;

  typedef struct {
    logic [DW-1:0] din;
    logic [3:0]    idx;
    logic [DW-1:0] dexp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] e_scaled;
    logic [DW-1:0] e_plain;
  } svec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;

  smp_t          exp_q[$];
  logic [DW-1:0] in_buf[$];
  bit            m_ovf;
  bit            m_ready;
  bit            m_valid;
  int            m_frames;
  smp_t          hd;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [3:0]    prev_idx;

  vec_t  tbl[N];
  svec_t stbl[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LG; i++)
      if (((k >> i) & 1) != 0) r = r | (1 << (LG - 1 - i));
    return r;
  endfunction

  function automatic int fdiv(input int x);
    if (x >= 0) return x / N;
    return -((-x + N - 1) / N);
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] s);
`ifdef REORDER_SCALE_EN
    logic [16:0] rp;
    logic [16:0] ip;
    int re;
    int im;
    rp = s[33:17];
    ip = s[16:0];
    re = fdiv(int'($signed(rp)));
    im = fdiv(int'($signed(ip)));
    return {17'(re), 17'(im)};
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Reference model: completed frames queued in natural order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      in_buf.delete();
      m_ovf = 1'b0;
      prev_stall = 1'b0;
    end else begin
      m_frames = (exp_q.size() + N - 1) / N;
      m_ready = m_frames < 2;
      m_valid = m_frames > 0;
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      if (m_valid) begin
        hd = exp_q[0];
        chk("out_index", 64'(bus.out_index), 64'(hd.idx));
        chk("data_out", 64'(bus.data_out), 64'(scale(hd.data)));
      end else begin
        chk("data_idle", 64'(bus.data_out), 64'(0));
      end
      if (prev_stall) begin
        chk("hold_data", 64'(bus.data_out), 64'(prev_data));
        chk("hold_index", 64'(bus.out_index), 64'(prev_idx));
      end
      prev_stall = m_valid && !bus.out_ready;
      prev_data = bus.data_out;
      prev_idx = bus.out_index;
      if (m_valid && bus.out_ready) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      if (bus.in_valid && !m_ready) m_ovf = 1'b1;
      if (bus.in_valid && m_ready) begin
        in_buf.push_back(bus.data_in);
        if (in_buf.size() == N) begin
          for (int n = 0; n < N; n++)
            exp_q.push_back('{4'(n), in_buf[brev(n)]});
          in_buf.delete();
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.data_in = d;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0) && (t < 200)) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    int exp_nat[16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                        1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < N; i++) begin
      tbl[i].din  = DW'(i);
      tbl[i].idx  = 4'(i);
      tbl[i].dexp = DW'(exp_nat[i]);
    end
    stbl[0] = '{{17'h1FFF0, 17'd17}, {17'h1FFFF, 17'd1},
                {17'h1FFF0, 17'd17}};
    stbl[1] = '{{17'h1FFFF, 17'h1FFFF}, {17'h1FFFF, 17'h1FFFF},
                {17'h1FFFF, 17'h1FFFF}};
    stbl[2] = '{{17'd31, 17'h1FFEF}, {17'd1, 17'h1FFFE},
                {17'd31, 17'h1FFEF}};
    stbl[3] = '{{17'h10000, 17'h0FFFF}, {17'h1F000, 17'h00FFF},
                {17'h10000, 17'h0FFFF}};

    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_index", 64'(bus.out_index), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    for (int k = 0; k < N; k++) send(tbl[k].din);
    @(negedge clk);
    chk("lat_pre", 64'(bus.out_valid), 64'(0));
    idle();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("basic_valid", 64'(bus.out_valid), 64'(1));
      chk("basic_index", 64'(bus.out_index), 64'(tbl[i].idx));
      chk("basic_data", 64'(bus.data_out), 64'(scale(tbl[i].dexp)));
    end
    @(negedge clk);
    chk("basic_done", 64'(bus.out_valid), 64'(0));

    base = xfers;
    for (int k = 0; k < 3 * N; k++) begin
      send(rnd());
      @(negedge clk);
      chk("stream_ready", 64'(bus.in_ready), 64'(1));
    end
    idle();
    drain("stream_drain");
    chk("stream_count", 64'(xfers - base), 64'(3 * N));
    chk("stream_ovf", 64'(bus.overflow), 64'(0));

    bus.out_ready = 1'b0;
    for (int k = 0; k < 2 * N; k++) send(rnd());
    send(rnd());
    @(negedge clk);
    chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    idle();
    @(negedge clk);
    chk("bp_overflow", 64'(bus.overflow), 64'(1));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("bp_ready_pre", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_back", 64'(bus.in_ready), 64'(1));
    drain("bp_drain");

    bus.out_ready = 1'b0;
    for (int k = 0; k < N; k++) send(rnd());
    idle();
    base = xfers;
    cnt = 0;
    while ((xfers - base < N) && (cnt < 80)) begin
      @(posedge clk);
      #1;
      bus.out_ready = ~bus.out_ready;
      cnt++;
    end
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("hs_count", 64'(xfers - base), 64'(N));
    @(negedge clk);
    chk("hs_empty", 64'(bus.out_valid), 64'(0));

    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) send(rnd());
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_ovf", 64'(bus.overflow), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      send(DW'(100 + k));
      @(negedge clk);
      chk("mid_wait", 64'(bus.out_valid), 64'(0));
    end
    idle();
    @(negedge clk);
    chk("mid_idx0", 64'(bus.data_out), 64'(scale(DW'(100))));
    @(negedge clk);
    chk("mid_idx1_i", 64'(bus.out_index), 64'(1));
    chk("mid_idx1_d", 64'(bus.data_out), 64'(scale(DW'(108))));
    drain("mid_drain");

    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++)
      send(k < 4 ? stbl[k].din : '0);
    idle();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (brev(j) == i)
`ifdef REORDER_SCALE_EN
          chk("scale_data", 64'(bus.data_out), 64'(stbl[j].e_scaled));
`else
          chk("plain_data", 64'(bus.data_out), 64'(stbl[j].e_plain));
`endif
    end
    drain("scale_drain");

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ($urandom() % 4) != 0;
      bus.data_in = rnd();
      bus.out_ready = ($urandom() % 3) != 0;
    end
    idle();
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output stage placed directly downstream of the fft core.
- The fft core emits each N-point frame in bit-reversed index order. This block buffers each frame and re-emits it in natural index order with a valid/ready handshake.
- Uses a ping-pong pair of register banks, so input streaming continues while the previous frame drains.
- Sample format matches the fft data bus: 34 bits, [33:17] signed real, [16:0] signed imaginary.

Parameters:
DATA_W, 34, sample width (real in upper half, imag in lower half, each DATA_W/2 signed)
LOG2N, 4, log2 of frame length; N = 2**LOG2N = 16

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in carries a sample from the fft core
in_ready  output  1  write bank has room; sample accepted when in_valid && in_ready
data_in  input  DATA_W  sample, arriving in bit-reversed order within the frame
out_valid  output  1  data_out/out_index valid
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready
data_out  output  DATA_W  sample in natural order
out_index  output  LOG2N  natural-order index of data_out
overflow  output  1  sticky; in_valid seen while in_ready low

Behaviour:
- Reset (async assert, sync-free deassert) clears the following:
  - wr_cnt, rd_cnt, wr_bank and rd_bank go to 0.
  - bank_full[1:0] goes to 0.
  - overflow goes to 0.
  - Outputs: out_valid 0, in_ready 1, out_index 0, data_out 0.
  - Bank contents are not cleared.
- in_ready = ~bank_full[wr_bank], combinational from registers.
- Write on accept:
  - bank[wr_bank][bitrev(wr_cnt)] <= data_in; wr_cnt increments.
  - When wr_cnt == N-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- out_valid = bank_full[rd_bank]; out_index = rd_cnt; data_out = bank[rd_bank][rd_cnt].
  - When out_valid is 0, data_out is forced to 0.
- Read on transfer: rd_cnt increments.
  - When rd_cnt == N-1: bank_full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- Latency: out_valid rises the cycle after the last sample of a frame is accepted, i.e. N cycles from the first accept at full rate.
- Holding: while out_valid && !out_ready, data_out and out_index hold stable.
- Simultaneous events:
  - A frame completing on the write side and a bank freeing on the read side in the same cycle are independent. Each updates its own bank_full bit.
  - A bank freed at edge t accepts writes from cycle t onward (in_ready high that cycle).
- Throughput: sustained 1 sample/cycle with out_ready held high; in_ready never drops.
- Both banks full: in_ready is 0. Any in_valid in that cycle is dropped (no write, wr_cnt unchanged) and sets overflow. overflow is cleared only by reset.
- Reset mid-frame discards the partial frame and any buffered frames; the first post-reset frame writes to bank 0.
- bitrev(k) reverses the LOG2N bits of k.

Optional Feature:
- Macro REORDER_SCALE_EN.
- Defined: data_out real and imag parts are each arithmetic-right-shifted by LOG2N (floor toward -inf). This gives 1/N normalisation. The shift is applied on the read path; stored data is unscaled.
- Undefined: data_out passes the stored sample unchanged.
- Handshake and timing are identical in both cases.

Test Plan:
- Basic reorder, out_ready=1:
  - Stimulus: 16 samples with data_in = k, k = 0..15, one per cycle.
  - Required: out_valid rises 1 cycle after the 16th accept; out_index 0..15 shows data 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Streaming, out_ready=1:
  - Stimulus: three back-to-back frames (48 consecutive in_valid cycles).
  - Required: in_ready stays 1 throughout; 48 outputs in natural order per frame; overflow stays 0.
- Backpressure overflow, out_ready=0:
  - Stimulus: feed 32 samples, then present a 33rd.
  - Required: in_ready falls after the 32nd accept; the 33rd is dropped and overflow = 1.
  - Then raise out_ready: frame 0 drains, and in_ready returns to 1 the cycle after its index 15 transfers.
- Handshake stability:
  - Stimulus: toggle out_ready every cycle during a drain.
  - Required: data_out and out_index unchanged on stalled cycles; exactly 16 transfers per frame.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 7 accepts, release, then feed one full frame of values 100+k.
  - Required: out_valid stays 0 until that frame completes; output at index 1 = 108, no stale data.
- Scaling (REORDER_SCALE_EN defined):
  - Stimulus: a frame with sample real=-16 (17'h1FFF0), imag=+17.
  - Required: output shows real=-1, imag=1.
  - Without the macro: output shows real=-16, imag=17.
